// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared defaults and helpers for the sobel window generator
package sobel_pkg;

    localparam int SOBEL_PIX_W      = 8;
    localparam int SOBEL_IMG_WIDTH  = 640;
    localparam int SOBEL_IMG_HEIGHT = 480;
    localparam int SOBEL_WIN_SIZE   = 9;

    // Counter width that still yields at least one bit for tiny images.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - DEPTH x PIX_W enabled delay line, no reset on storage
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = SOBEL_IMG_WIDTH,
    parameter int PIX_W = SOBEL_PIX_W
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - raster 3x3 window generator; optional frame_err via SOBEL_WINDOW_FRAME_ERR_EN
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = SOBEL_IMG_WIDTH,
    parameter int IMG_HEIGHT = SOBEL_IMG_HEIGHT,
    parameter int PIX_W      = SOBEL_PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    output logic             win_valid,
    output logic             frame_done
`ifdef SOBEL_WINDOW_FRAME_ERR_EN
    ,
    output logic             frame_err
`endif
);

    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]    col;
    logic [CW-1:0]    cur_col;
    logic [RW-1:0]    row;
    logic [RW-1:0]    cur_row;
    logic             at_last;
    logic [PIX_W-1:0] lb1_dout;
    logic [PIX_W-1:0] lb2_dout;
    logic [PIX_W-1:0] win [SOBEL_WIN_SIZE];

    // Position of the pixel on pix_in this cycle; sof forces it to (0,0).
    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
        at_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end else if (sof) begin
            col <= '0;
            row <= '0;
        end
    end

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
        .clk  (clk),
        .en   (pix_valid & ~rst),
        .din  (pix_in),
        .dout (lb1_dout)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb2 (
        .clk  (clk),
        .en   (pix_valid & ~rst),
        .din  (lb1_dout),
        .dout (lb2_dout)
    );

    // Window registers are the outputs; they only move on accepted pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SOBEL_WIN_SIZE; i++) begin
                win[i] <= '0;
            end
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (pix_valid) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb2_dout;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb1_dout;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= pix_in;
            end
            win_valid  <= pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            frame_done <= pix_valid && at_last;
        end
    end

`ifdef SOBEL_WINDOW_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= sof && ((col != '0) || (row != '0));
        end
    end
`endif

    assign p0 = win[0];
    assign p1 = win[1];
    assign p2 = win[2];
    assign p3 = win[3];
    assign p4 = win[4];
    assign p5 = win[5];
    assign p6 = win[6];
    assign p7 = win[7];
    assign p8 = win[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - table-driven bench for sobel_window_gen on a 4x4 image
module tb_sobel_window_gen;

    typedef struct {
        logic       rst;
        logic       pv;
        logic       sof;
        logic [7:0] pix;
        logic       wv;
        logic       fd;
        logic       fe;
        logic       chk_zero;
        logic       chk_win;
        int         wr;
        int         wc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pix_in = 8'h00;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic       win_valid;
    logic       frame_done;
`ifdef SOBEL_WINDOW_FRAME_ERR_EN
    logic       frame_err;
`endif

    logic [7:0] pa [9];
    assign pa[0] = p0;
    assign pa[1] = p1;
    assign pa[2] = p2;
    assign pa[3] = p3;
    assign pa[4] = p4;
    assign pa[5] = p5;
    assign pa[6] = p6;
    assign pa[7] = p7;
    assign pa[8] = p8;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   wv_seen = 0;
    vec_t vecs[$];
    int   br = 0;
    int   bc = 0;
    logic last_wv = 1'b0;
    int   last_r = 0;
    int   last_c = 0;
    logic [7:0] first_win [9] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .p0         (p0),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .win_valid  (win_valid),
        .frame_done (frame_done)
`ifdef SOBEL_WINDOW_FRAME_ERR_EN
        ,
        .frame_err  (frame_err)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int win_exp(input int r, input int c, input int k);
        return ((r - 2 + k / 3) * 16) + (c - 2 + k % 3);
    endfunction

    function automatic vec_t blank();
        vec_t v;
        v.rst = 0; v.pv = 0; v.sof = 0; v.pix = 8'h00;
        v.wv = 0; v.fd = 0; v.fe = 0; v.chk_zero = 0; v.chk_win = 0;
        v.wr = 0; v.wc = 0;
        return v;
    endfunction

    task automatic add_px(input logic s);
        vec_t v;
        v = blank();
        if (s) begin
            v.fe = (br != 0 || bc != 0);
            br = 0;
            bc = 0;
        end
        v.pv = 1'b1;
        v.sof = s;
        v.pix = 8'(br * 16 + bc);
        v.wv = (br >= 2 && bc >= 2);
        v.fd = (br == 3 && bc == 3);
        v.chk_win = v.wv;
        v.wr = br;
        v.wc = bc;
        last_wv = v.wv;
        last_r = br;
        last_c = bc;
        bc++;
        if (bc == 4) begin
            bc = 0;
            br = (br == 3) ? 0 : br + 1;
        end
        vecs.push_back(v);
    endtask

    task automatic add_gap(input logic s);
        vec_t v;
        v = blank();
        v.sof = s;
        v.pix = 8'hee;
        if (s) begin
            v.fe = (br != 0 || bc != 0);
            br = 0;
            bc = 0;
        end
        v.chk_win = last_wv;
        v.wr = last_r;
        v.wc = last_c;
        vecs.push_back(v);
    endtask

    task automatic add_rst(input logic pv, input logic s);
        vec_t v;
        v = blank();
        v.rst = 1'b1;
        v.pv = pv;
        v.sof = s;
        v.pix = 8'hff;
        v.chk_zero = 1'b1;
        br = 0;
        bc = 0;
        last_wv = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic add_frame(input logic s, input logic gaps);
        for (int k = 0; k < 16; k++) begin
            add_px(s && (k == 0));
            if (gaps) add_gap(1'b0);
        end
    endtask

    task automatic add_pixels(input int n);
        for (int k = 0; k < n; k++) add_px(1'b0);
    endtask

    task automatic step(input logic r, input logic pv, input logic s, input logic [7:0] px);
        rst = r;
        pix_valid = pv;
        sof = s;
        pix_in = px;
        @(posedge clk);
        #1;
    endtask

    initial begin
        add_rst(1'b0, 1'b0);
        add_rst(1'b1, 1'b1);
        add_frame(1'b1, 1'b0);
        add_frame(1'b0, 1'b1);
        add_pixels(6);
        add_frame(1'b1, 1'b0);
        add_pixels(5);
        add_gap(1'b1);
        add_frame(1'b0, 1'b0);
        add_pixels(10);
        add_rst(1'b1, 1'b1);
        add_frame(1'b0, 1'b0);
        add_frame(1'b1, 1'b0);
        add_frame(1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            step(v.rst, v.pv, v.sof, v.pix);
            if (win_valid) wv_seen++;
            check($sformatf("win_valid[%0d]", i), int'(win_valid), int'(v.wv));
            check($sformatf("frame_done[%0d]", i), int'(frame_done), int'(v.fd));
`ifdef SOBEL_WINDOW_FRAME_ERR_EN
            check($sformatf("frame_err[%0d]", i), int'(frame_err), int'(v.fe));
`endif
            if (v.chk_zero) begin
                for (int k = 0; k < 9; k++)
                    check($sformatf("reset_p%0d[%0d]", k, i), int'(pa[k]), 0);
            end
            if (v.chk_win) begin
                for (int k = 0; k < 9; k++)
                    check($sformatf("win_p%0d[%0d]", k, i), int'(pa[k]), win_exp(v.wr, v.wc, k));
            end
        end
        check("window_count", wv_seen, 28);

        // Hand-written replay of the continuous frame with literal first window.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("hand_reset_wv", int'(win_valid), 0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b0, 1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
                if (r == 2 && c == 2) begin
                    check("hand_first_wv", int'(win_valid), 1);
                    for (int k = 0; k < 9; k++)
                        check($sformatf("hand_first_p%0d", k), int'(pa[k]), int'(first_win[k]));
                end
                if (r == 3 && c == 3) begin
                    check("hand_last_p8", int'(p8), 'h33);
                    check("hand_last_wv", int'(win_valid), 1);
                    check("hand_last_fd", int'(frame_done), 1);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("hand_idle_wv", int'(win_valid), 0);
        check("hand_idle_fd", int'(frame_done), 0);
        check("hand_hold_p8", int'(p8), 'h33);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640: pixels per line, minimum 3.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480: lines per frame, minimum 3.
REQ-003 SHALL have parameter PIX_W, default 8: bits per pixel.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pix_in, input, PIX_W bits: raster-order pixel.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_in is accepted this cycle; there is no backpressure.
REQ-008 SHALL have port sof, input, 1 bit: start of frame.
REQ-009 SHALL have ports p0..p8, output, PIX_W bits each: 3x3 window in the sobel_module neighbour order.
- p0 p1 p2: row r-2.
- p3 p4 p5: row r-1.
- p6 p7 p8: row r.
- Within each row, left to right is columns c-2, c-1, c.
REQ-010 SHALL have port win_valid, output, 1 bit: p0..p8 hold a complete in-frame window.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame.

Function
REQ-012 SHALL hold column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), each $clog2-sized.
REQ-013 SHALL advance col only on pix_valid.
- col wraps to 0 after IMG_WIDTH-1 and row increments on that wrap.
- row wraps to 0 after IMG_HEIGHT-1.
REQ-014 SHALL, on pix_valid, shift the pixel into the bottom window row and two IMG_WIDTH-deep line buffers.
- Line buffer 1 supplies the middle row; line buffer 2 supplies the top row.
- Each window row shifts left by one column.
REQ-015 SHALL register outputs with 1-cycle latency: win_valid=1 in the cycle after a pix_valid pixel at (row>=2, col>=2), else 0.
REQ-016 SHALL, when win_valid=1, set p8 to that pixel and p0 to the pixel at (row-2, col-2).
REQ-017 SHALL hold p0..p8 unchanged while win_valid=0 and no pix_valid arrives.
REQ-018 SHALL emit exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) win_valid pulses per frame.
- Windows straddling a line wrap (col<2) are suppressed.
REQ-019 SHALL pulse frame_done in the cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted, coincident with the final win_valid.
REQ-020 SHALL handle sof as follows.
- sof with pix_valid: the pixel is treated as (0,0).
- sof without pix_valid: col and row clear, and the next valid pixel is (0,0).
REQ-021 SHALL NOT clear line buffer contents on sof; stale data is masked by the row>=2 rule.
REQ-022 SHALL treat pix_valid gaps of any length as transparent: window contents are identical to a gap-free stream.

Reset
REQ-023 SHALL, in the cycle after rst=1, hold col=0, row=0, p0..p8=0, win_valid=0 and frame_done=0.
REQ-024 SHALL ignore pix_valid and sof while rst=1.
REQ-025 SHALL NOT require line buffer contents to be reset.
REQ-026 SHALL make reset mid-frame abandon the frame; the next valid pixel is (0,0).

Configuration
REQ-027 SHALL, with SOBEL_WINDOW_FRAME_ERR_EN defined, add output frame_err (1 bit).
- frame_err is a one-cycle pulse in the cycle after sof arrives while (row,col) != (0,0), i.e. a short frame.
- frame_err is 0 on reset.
REQ-028 SHALL, without SOBEL_WINDOW_FRAME_ERR_EN, have no frame_err port and no related logic.

Structure
REQ-029 SHALL take PIX_W, IMG_WIDTH and IMG_HEIGHT defaults from the shared package sobel_pkg.
REQ-030 SHALL instantiate sub-module sobel_line_buffer twice.
- sobel_line_buffer is a parameterised DEPTH x PIX_W delay line with clk, shift enable, din and dout.
- Its dout is din delayed by DEPTH enabled shifts.

Verification
REQ-031 SHALL be verified with IMG_WIDTH=4, IMG_HEIGHT=4 and pixel value = row*16+col, covering these scenarios.
- Reset: rst=1 for 2 cycles -> p0..p8=0, win_valid=0, frame_done=0.
- Continuous 4x4 frame 0x00..0x33 -> exactly 4 win_valid pulses.
  - First pulse, the cycle after 0x22: p0..p8 = 00,01,02,10,11,12,20,21,22.
  - Last pulse: p8=0x33, with frame_done=1 in the same cycle.
- Same frame with pix_valid low every other cycle -> identical 4 windows, each pulse one cycle after its valid pixel.
- sof after 6 pixels, then a full frame -> first window identical to the continuous-frame case; with the macro, frame_err=1 for one cycle.
- rst after 10 pixels -> outputs 0 next cycle; the following frame gives the continuous-frame results exactly.
- Two back-to-back frames, sof on each first pixel -> 8 windows; the second frame's first window equals the first frame's.
